jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter RPT_W, default 4, is the width of the command repeat field.
REQ-002 Port clk, input, 1: the single clock, with all state updated on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset, shared with the downstream JK flip-flop.
REQ-004 Port cmd_valid, input, 1: a command is offered.
REQ-005 Port cmd_ready, output, 1: the block can accept a command.
REQ-006 Port cmd_op, input, 2: 00 hold, 01 clear, 10 set, 11 toggle (the JK {j,k} encoding).
REQ-007 Port cmd_rpt, input, RPT_W: the number of applications is cmd_rpt+1.
REQ-008 Port clr_err, input, 1: synchronous clear of err.
REQ-009 Port q_fb, input, 1: q fed back from the downstream JK flip-flop.
REQ-010 Port j, output, 1: J drive to the downstream flip-flop.
REQ-011 Port k, output, 1: K drive to the downstream flip-flop.
REQ-012 Port exp_q, output, 1: predicted downstream q.
REQ-013 Port busy, output, 1: a command is in progress.
REQ-014 Port done, output, 1: one-cycle pulse at command completion.
REQ-015 Port err, output, 1: sticky mismatch flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, DRIVE and CHECK.
REQ-017 cmd_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in DRIVE and CHECK.
REQ-018 A command SHALL be accepted on an edge with cmd_valid=1 and cmd_ready=1, which latches op, sets rem=cmd_rpt and moves to DRIVE.
REQ-019 In DRIVE, registered j and k SHALL equal the latched op bits for exactly one cycle.
REQ-020 At the edge ending DRIVE, exp_q SHALL update per the JK rule (00 keep, 01 to 0, 10 to 1, 11 invert) and the FSM SHALL move to CHECK.
REQ-021 In CHECK, j and k SHALL be 0.
REQ-022 At the edge ending CHECK, q_fb SHALL be compared with exp_q, and a mismatch SHALL set err.
REQ-023 At the edge ending CHECK with rem=0, the FSM SHALL go to IDLE and done SHALL be 1 for the following cycle.
REQ-024 At the edge ending CHECK with rem>0, rem SHALL be decremented and the FSM SHALL return to DRIVE.
REQ-025 Latency SHALL be exactly 2*(cmd_rpt+1) cycles from acceptance to the done cycle.
REQ-026 A new command SHALL NOT be accepted in the done cycle, because cmd_ready returns to 1 in that same cycle and acceptance occurs at the next edge.
REQ-027 cmd_valid while busy SHALL be ignored, with no queuing.
REQ-028 Op hold SHALL still run all phases, with j=k=0 and the check performed.
REQ-029 With cmd_rpt at its maximum (2^RPT_W-1), the command SHALL run 2^RPT_W applications, and rem SHALL NOT wrap or underflow.
REQ-030 When clr_err and a mismatch occur on the same edge, err SHALL be set (set wins).
REQ-031 err SHALL be cleared only by reset or by clr_err without a simultaneous mismatch.

Reset
REQ-032 While reset is asserted, the FSM SHALL be in IDLE and j=0, k=0, exp_q=0, busy=0, done=0, err=0, rem=0, with cmd_ready=1 from the first clock edge after deassertion.
REQ-033 Reset asserted mid-command SHALL abort the command immediately with no done pulse, with exp_q=0 matching the downstream reset value of 0.

Structure
REQ-034 Package jk_pkg SHALL hold the op encoding constants (OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE) and the FSM state enum.
REQ-035 Sub-module jk_next_state SHALL be the combinational JK next-state function (q, j, k to q_next), reused by the sequencer and the bench model.

Verification
REQ-036 After reset, the bench SHALL check: reset pulse -> cmd_ready=1, j=k=0, exp_q=0, err=0.
REQ-037 Set then toggle: op=10, rpt=0 then op=11, rpt=0 -> j=1 for one cycle, done at cycle 2, exp_q=1; then j=k=1 for one cycle, done at cycle 2, exp_q=0; err=0.
REQ-038 Toggle with repeat: op=11, rpt=3 -> four DRIVE/CHECK pairs, exp_q sequence 1,0,1,0, done at cycle 8, busy for 8 cycles.
REQ-039 Fault injection: q_fb forced to 0 during op=10 -> err=1 at the CHECK edge; err held through the following command; clr_err pulse -> err=0.
REQ-040 Reset mid-command: op=11, rpt=5, reset asserted in the 3rd cycle -> immediate IDLE, exp_q=0, no done pulse, and the next command is accepted normally.
REQ-041 Busy backpressure: cmd_valid held high through a rpt=1 command -> exactly one command accepted per done, with the next acceptance at the edge ending the done cycle.

Source files
------------

// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK command sequencer:
//   - OP_* : command op encoding, identical to the JK {j,k} input pair
//   - state_t : sequencer FSM states
// ---------------------------------------------------------------------------
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/jk_next_state.sv
// ---------------------------------------------------------------------------
// jk_next_state
// Combinational JK flip-flop next-state function.
// Ports:
//   q      in  : current flip-flop state
//   j, k   in  : JK drive pair
//   q_next out : state after one clock edge with this drive
// ---------------------------------------------------------------------------
module jk_next_state
  import jk_pkg::*;
(
  input  logic q,
  input  logic j,
  input  logic k,
  output logic q_next
);

  always_comb begin
    q_next = q;
    case ({j, k})
      OP_HOLD:   q_next = q;
      OP_CLEAR:  q_next = 1'b0;
      OP_SET:    q_next = 1'b1;
      OP_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer
// Accepts {op, repeat} commands and applies the op (cmd_rpt+1) times to a
// downstream JK flip-flop, one DRIVE cycle followed by one CHECK cycle per
// application. It predicts the downstream q and flags a sticky error when
// the fed-back q disagrees with the prediction.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_op, cmd_rpt   : JK op and repeat count (applications = cmd_rpt+1)
//   clr_err           : synchronous clear of err (a same-edge mismatch wins)
//   q_fb              : q fed back from the downstream flip-flop
//   j, k              : registered drive to the downstream flip-flop
//   exp_q             : predicted downstream q
//   busy, done, err   : command in progress, completion pulse, sticky error
// ---------------------------------------------------------------------------
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int RPT_W = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RPT_W-1:0] cmd_rpt,
  input  logic             clr_err,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             exp_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [RPT_W-1:0] r_rem;
  logic             r_j;
  logic             r_k;
  logic             r_exp_q;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_mismatch;
  logic             w_q_next;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  // The downstream flop updated at the edge ending DRIVE, so during CHECK
  // its q must already equal the prediction.
  assign w_mismatch = (r_state == ST_CHECK) && (q_fb != r_exp_q);

  // Prediction uses the registered drive, i.e. exactly what the downstream
  // flop sees at the edge ending DRIVE.
  jk_next_state u_next (
    .q      (r_exp_q),
    .j      (r_j),
    .k      (r_k),
    .q_next (w_q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_rem   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_exp_q <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Set has priority over clear so a mismatch is never lost.
      if (w_mismatch) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_rem   <= cmd_rpt;
            r_j     <= cmd_op[1];
            r_k     <= cmd_op[0];
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_exp_q <= w_q_next;
          r_j     <= 1'b0;
          r_k     <= 1'b0;
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (r_rem == '0) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            // Only reached with r_rem > 0, so the decrement cannot underflow.
            r_rem   <= r_rem - RPT_W'(1);
            r_j     <= r_op[1];
            r_k     <= r_op[0];
            r_state <= ST_DRIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign j         = r_j;
  assign k         = r_k;
  assign exp_q     = r_exp_q;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Bench for jk_cmd_sequencer with a downstream JK flip-flop model whose
// feedback can be forced to 0 to inject mismatches. Expected results are
// pushed to a scoreboard queue when a command is driven and popped when the
// DUT pulses done.
// ---------------------------------------------------------------------------
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  localparam int RPT_W = 4;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op    = 2'b00;
  logic [RPT_W-1:0] cmd_rpt   = '0;
  logic             clr_err   = 1'b0;
  logic             q_fb;
  logic             cmd_ready;
  logic             j;
  logic             k;
  logic             exp_q;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.RPT_W(RPT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rpt   (cmd_rpt),
    .clr_err   (clr_err),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .exp_q     (exp_q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Downstream JK flip-flop sharing the reset.
  logic ff_q;
  logic ff_q_next;
  logic force_fb0 = 1'b0;

  jk_next_state u_ff_next (
    .q      (ff_q),
    .j      (j),
    .k      (k),
    .q_next (ff_q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= 1'b0;
    else       ff_q <= ff_q_next;
  end

  assign q_fb = force_fb0 ? 1'b0 : ff_q;

  // Scoreboard
  typedef struct {
    logic q;
    logic e;
    int   lat;
  } sb_rec_t;

  sb_rec_t sb_q[$];
  logic    m_q   = 1'b0;
  logic    m_err = 1'b0;
  int      n_checks = 0;
  int      n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic ref_jk(input logic q, input logic [1:0] op);
    case (op)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // Runs one command from IDLE; optionally pulses clr_err in the last CHECK.
  task automatic run_cmd(input logic [1:0] op, input int rpt, input logic clr_last);
    logic    seq[$];
    sb_rec_t rec;
    int      c;
    bit      seen;
    check_val("ready_before_cmd", cmd_ready, 1);
    for (int i = 0; i <= rpt; i++) begin
      m_q = ref_jk(m_q, op);
      seq.push_back(m_q);
      if (force_fb0 && m_q) m_err = 1'b1;
      else if (clr_last && i == rpt) m_err = 1'b0;
    end
    rec.q = m_q; rec.e = m_err; rec.lat = 2 * (rpt + 1);
    sb_q.push_back(rec);

    cmd_valid = 1'b1; cmd_op = op; cmd_rpt = RPT_W'(rpt);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("busy_after_accept", busy, 1);
    c = 0; seen = 0;
    while (!seen && c <= 2 * (rpt + 1) + 4) begin
      if (done) begin
        seen = 1;
      end else begin
        if (c % 2 == 0) begin
          check_val("drive_jk", {30'd0, j, k}, {30'd0, op});
        end else begin
          check_val("check_jk", {30'd0, j, k}, 0);
          if ((c - 1) / 2 < seq.size())
            check_val("check_exp_q", exp_q, seq[(c - 1) / 2]);
        end
        if (clr_last && c == 2 * rpt + 1) clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        c++;
      end
    end
    check_val("done_seen", seen, 1);
    rec = sb_q.pop_front();
    check_val("latency", c, rec.lat);
    check_val("done_exp_q", exp_q, rec.q);
    check_val("done_err", err, rec.e);
    check_val("done_not_busy", busy, 0);
    check_val("done_ready", cmd_ready, 1);
    $display("cmd op=%0b rpt=%0d lat=%0d exp_q=%0b err=%0b", op, rpt, c, exp_q, err);
    @(posedge clk); #1;
    check_val("done_one_cycle", done, 0);
  endtask

  initial begin
    sb_rec_t rec;
    int      lat;
    bit      seen;
    bit      saw_done;

    // Reset state
    #1;
    check_val("rst_ready", cmd_ready, 1);
    check_val("rst_jk", {30'd0, j, k}, 0);
    check_val("rst_exp_q", exp_q, 0);
    check_val("rst_err", err, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_ready", cmd_ready, 1);

    // Set then toggle
    run_cmd(OP_SET, 0, 1'b0);
    run_cmd(OP_TOGGLE, 0, 1'b0);
    // Toggle with repeat
    run_cmd(OP_TOGGLE, 3, 1'b0);
    // Hold and clear, from q=1
    run_cmd(OP_SET, 0, 1'b0);
    run_cmd(OP_HOLD, 1, 1'b0);
    run_cmd(OP_CLEAR, 2, 1'b0);

    // Fault injection: mismatch sets err, which then sticks
    force_fb0 = 1'b1;
    run_cmd(OP_SET, 0, 1'b0);
    force_fb0 = 1'b0;
    run_cmd(OP_TOGGLE, 0, 1'b0);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0; m_err = 1'b0;
    check_val("err_after_clr", err, m_err);
    $display("clr_err pulse err=%0b", err);

    // clr_err coinciding with a mismatch: set wins
    force_fb0 = 1'b1;
    run_cmd(OP_SET, 0, 1'b1);
    force_fb0 = 1'b0;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0; m_err = 1'b0;
    check_val("err_after_clr2", err, m_err);

    // Maximum repeat: 16 applications, no wrap
    run_cmd(OP_TOGGLE, (1 << RPT_W) - 1, 1'b0);

    // Reset mid-command
    check_val("ready_before_abort", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_TOGGLE; cmd_rpt = RPT_W'(5);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    m_q = 1'b0; m_err = 1'b0;
    check_val("abort_ready", cmd_ready, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_exp_q", exp_q, m_q);
    check_val("abort_jk", {30'd0, j, k}, 0);
    check_val("abort_done", done, 0);
    check_val("abort_err", err, m_err);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_val("abort_post_ready", cmd_ready, 1);
    saw_done = 0;
    repeat (14) begin
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    check_val("abort_no_done", saw_done, 0);
    $display("reset mid-command aborted exp_q=%0b", exp_q);
    run_cmd(OP_SET, 0, 1'b0);

    // Backpressure: cmd_valid held through busy
    cmd_valid = 1'b1; cmd_op = OP_TOGGLE; cmd_rpt = RPT_W'(1);
    for (int n = 0; n < 3; n++) begin
      m_q = ref_jk(ref_jk(m_q, OP_TOGGLE), OP_TOGGLE);
      rec.q = m_q; rec.e = m_err; rec.lat = 5;
      sb_q.push_back(rec);
      lat = 0; seen = 0;
      while (!seen && lat < 12) begin
        @(posedge clk); #1;
        lat++;
        if (done) seen = 1;
      end
      if (n == 2) cmd_valid = 1'b0;
      check_val("bp_done_seen", seen, 1);
      rec = sb_q.pop_front();
      check_val("bp_latency", lat, rec.lat);
      check_val("bp_exp_q", exp_q, rec.q);
      check_val("bp_err", err, rec.e);
      $display("bp cmd %0d lat=%0d exp_q=%0b", n, lat, exp_q);
    end
    @(posedge clk); #1;
    check_val("bp_no_extra_accept", busy, 0);
    check_val("bp_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
